adder_tree_pipe: RTL and testbench

ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

---
 rtl/adder_pkg.sv | 14 +
 rtl/add_level_reg.sv | 38 +++
 rtl/adder_tree_pipe.sv | 72 +++++++
 tb/tb_adder_tree_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder tree.
package adder_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_NUM_IN = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/add_level_reg.sv
// One registered level of the adder tree: PAIRS independent pair sums, each
// one bit wider than its operands, extended by sign or zero per the vector mode.
module add_level_reg #(
    parameter int IN_W  = 12,
    parameter int PAIRS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      i_sgn,
    input  logic [2*PAIRS*IN_W-1:0]   i_data,
    output logic [PAIRS*(IN_W+1)-1:0] o_data
);

    logic [PAIRS*(IN_W+1)-1:0] w_sum;
    logic [PAIRS*(IN_W+1)-1:0] r_data;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [IN_W-1:0] w_a;
        logic [IN_W-1:0] w_b;
        assign w_a = i_data[2*p*IN_W +: IN_W];
        assign w_b = i_data[(2*p+1)*IN_W +: IN_W];
        // One guard bit is enough to hold the exact sum of two operands.
        assign w_sum[p*(IN_W+1) +: IN_W+1] = {i_sgn & w_a[IN_W-1], w_a}
                                            + {i_sgn & w_b[IN_W-1], w_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (ce) begin
            r_data <= w_sum;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined binary adder tree: registered operand stage followed by
// log2(NUM_IN) registered pair-sum levels; one exact sum per enabled cycle.
module adder_tree_pipe
    import adder_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int LVL    = clog2(NUM_IN),
    localparam int SUM_W  = DATA_W + LVL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic                     in_signed,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic [SUM_W-1:0]         out_sum
);

    logic [NUM_IN*DATA_W-1:0] r_data;
    logic [LVL:0]             r_vld_pipe;
    // r_sgn_pipe[j] is the mode of the operands feeding level j.
    logic [LVL-1:0]           r_sgn_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_vld_pipe <= '0;
            r_sgn_pipe <= '0;
        end else if (ce) begin
            r_vld_pipe <= {r_vld_pipe[LVL-1:0], in_valid};
            if (in_valid) begin
                r_data        <= in_data;
                r_sgn_pipe[0] <= in_signed;
            end
            for (int j = 1; j < LVL; j++) begin
                r_sgn_pipe[j] <= r_sgn_pipe[j-1];
            end
        end
    end

    for (genvar j = 0; j < LVL; j++) begin : g_lvl
        localparam int IN_W  = DATA_W + j;
        localparam int PAIRS = NUM_IN >> (j + 1);

        logic [2*PAIRS*IN_W-1:0]   w_in;
        logic [PAIRS*(IN_W+1)-1:0] w_out;

        if (j == 0) begin : g_src
            assign w_in = r_data;
        end else begin : g_src
            assign w_in = g_lvl[j-1].w_out;
        end

        add_level_reg #(
            .IN_W  (IN_W),
            .PAIRS (PAIRS)
        ) u_lvl (
            .clk    (clk),
            .rst    (rst),
            .ce     (ce),
            .i_sgn  (r_sgn_pipe[j]),
            .i_data (w_in),
            .o_data (w_out)
        );
    end

    assign out_valid = r_vld_pipe[LVL];
    assign out_sum   = g_lvl[LVL-1].w_out;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench: default 8x12 tree with directed vectors, plus 2x4 and 32x32
// trees fed random operands under the same control sequence.
module tb_adder_tree_pipe;

    typedef struct {
        logic [63:0] sum;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, ce, in_valid, in_signed;
    logic [95:0]   data0;
    logic [7:0]    data1;
    logic [1023:0] data2;
    logic          o_vld0, o_vld1, o_vld2;
    logic [14:0]   o_sum0;
    logic [4:0]    o_sum1;
    logic [36:0]   o_sum2;
    logic [63:0]   exp0, exp1, exp2;

    exp_t q0[$], q1[$], q2[$];
    exp_t it;
    int   checks = 0, errors = 0;
    int   adv_cnt = 0;
    logic adv_q = 1'b0, rst_q = 1'b0;
    logic [14:0] prev_s0 = '0;
    logic        prev_v0 = 1'b0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.DATA_W(12), .NUM_IN(8)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .in_data(data0), .out_valid(o_vld0), .out_sum(o_sum0));
    adder_tree_pipe #(.DATA_W(4), .NUM_IN(2)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .in_data(data1), .out_valid(o_vld1), .out_sum(o_sum1));
    adder_tree_pipe #(.DATA_W(32), .NUM_IN(32)) u_dut2 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .in_data(data2), .out_valid(o_vld2), .out_sum(o_sum2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic spurious(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: out_valid=1 with no vector expected", nm);
    endtask

    function automatic logic [63:0] model_sum(input logic [1023:0] d, input int n,
                                              input int w, input bit sgn);
        longint s, v;
        logic [1023:0] t;
        s = 0;
        for (int k = 0; k < n; k++) begin
            t = d >> (k * w);
            v = longint'({32'd0, t[31:0]}) & ((64'sd1 <<< w) - 64'sd1);
            if (sgn && v[w-1]) v = v - (64'sd1 <<< w);
            s = s + v;
        end
        return 64'(s);
    endfunction

    function automatic logic [95:0] rep(input logic [11:0] x);
        return {8{x}};
    endfunction

    // Expected-value producer: captures what each DUT samples at this edge.
    always @(posedge clk) begin
        rst_q <= rst;
        adv_q <= ce && !rst;
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else if (ce) begin
            adv_cnt <= adv_cnt + 1;
            if (in_valid) begin
                q0.push_back('{exp0, adv_cnt + 4});
                q1.push_back('{exp1, adv_cnt + 2});
                q2.push_back('{exp2, adv_cnt + 6});
            end
        end
    end

    // Monitor: pops and compares whenever an advancing edge presents a result.
    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_vld_8x12", 64'(o_vld0), 64'd0);
            chk("rst_sum_8x12", 64'(o_sum0), 64'd0);
            chk("rst_vld_2x4", 64'(o_vld1), 64'd0);
            chk("rst_vld_32x32", 64'(o_vld2), 64'd0);
        end else if (!adv_q) begin
            chk("hold_sum_8x12", 64'(o_sum0), 64'(prev_s0));
            chk("hold_vld_8x12", 64'(o_vld0), 64'(prev_v0));
        end
        if (adv_q) begin
            if (o_vld0) begin
                if (q0.size() == 0) spurious("spurious_8x12");
                else begin
                    it = q0.pop_front();
                    chk("sum_8x12", 64'(o_sum0), 64'(it.sum[14:0]));
                    chk("lat_8x12", 64'(adv_cnt), 64'(it.due));
                end
            end
            if (o_vld1) begin
                if (q1.size() == 0) spurious("spurious_2x4");
                else begin
                    it = q1.pop_front();
                    chk("sum_2x4", 64'(o_sum1), 64'(it.sum[4:0]));
                    chk("lat_2x4", 64'(adv_cnt), 64'(it.due));
                end
            end
            if (o_vld2) begin
                if (q2.size() == 0) spurious("spurious_32x32");
                else begin
                    it = q2.pop_front();
                    chk("sum_32x32", 64'(o_sum2), 64'(it.sum[36:0]));
                    chk("lat_32x32", 64'(adv_cnt), 64'(it.due));
                end
            end
        end
        prev_s0 = o_sum0;
        prev_v0 = o_vld0;
    end

    // One cycle of stimulus; the small and wide trees always get fresh random data.
    task automatic step(input bit v, input bit s, input logic [95:0] d0,
                        input logic [63:0] e0, input bit c);
        in_valid  = v;
        in_signed = s;
        ce        = c;
        data0     = d0;
        exp0      = e0;
        data1     = 8'($urandom);
        for (int k = 0; k < 32; k++) data2[k*32 +: 32] = $urandom;
        exp1 = model_sum(1024'(data1), 2, 4, s);
        exp2 = model_sum(data2, 32, 32, s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int          ops[8] = '{1, -1, 2, -2, 3, -3, 4, -4};
        logic [95:0] v3, v6, rd;
        bit          rs;

        for (int k = 0; k < 8; k++) begin
            v3[k*12 +: 12] = 12'(ops[k]);
            v6[k*12 +: 12] = 12'(k + 1);
        end
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; exp0 = '0; exp1 = '0; exp2 = '0;
        idle(2);
        rst = 1'b0;

        // Boundary vectors issued back to back.
        step(1'b1, 1'b1, rep(12'h7FF), 64'h3FF8, 1'b1);
        step(1'b1, 1'b1, rep(12'h800), 64'h4000, 1'b1);
        step(1'b1, 1'b1, v3, 64'h0, 1'b1);
        step(1'b1, 1'b0, rep(12'hFFF), 64'h7FF8, 1'b1);
        step(1'b1, 1'b1, rep(12'hFFF), 64'h7FF8, 1'b1);
        step(1'b1, 1'b0, v6, 64'h24, 1'b1);
        idle(7);

        // Stall mid-flight; a valid offered while ce=0 must not be taken.
        step(1'b1, 1'b0, rep(12'h100), 64'h800, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rep(12'hABC), 64'h0, 1'b0);
        idle(6);

        // Reset with two vectors in flight: neither may ever appear.
        step(1'b1, 1'b1, rep(12'h7FF), 64'h3FF8, 1'b1);
        step(1'b1, 1'b0, rep(12'hFFF), 64'h7FF8, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);
        step(1'b1, 1'b1, rep(12'h001), 64'h8, 1'b1);
        idle(6);

        // Random regression with random enables across all three trees.
        for (int i = 0; i < 40; i++) begin
            rd = {$urandom, $urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 3) != 0), rs, rd, model_sum(1024'(rd), 8, 12, rs),
                 ($urandom_range(0, 4) != 0));
        end
        idle(10);

        chk("drain_8x12", 64'(q0.size()), 64'd0);
        chk("drain_2x4", 64'(q1.size()), 64'd0);
        chk("drain_32x32", 64'(q2.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
